// File: rtl/lane_map_if.sv
// lane_map_if -- stream bundle for lane_map_pipe.
// Build option: LANE_MAP_PARITY_EN adds m_par (per-lane even parity of m_data).
// Signals:
//   s_valid/s_ready/s_data/s_sof : input beat handshake, lane k = s_data[8k+7:8k]
//   m_valid/m_ready/m_data/m_sof : output beat handshake
//   m_par (optional)             : even parity per m_data lane
// Modports: master = environment (drives inputs, consumes outputs),
//           slave  = lane_map_pipe.
interface lane_map_if #(
  parameter int unsigned N_BYTES = 4
);
  logic                   s_valid;
  logic                   s_ready;
  logic [8*N_BYTES-1:0]   s_data;
  logic                   s_sof;
  logic                   m_valid;
  logic                   m_ready;
  logic [8*N_BYTES-1:0]   m_data;
  logic                   m_sof;
`ifdef LANE_MAP_PARITY_EN
  logic [N_BYTES-1:0]     m_par;

  modport master (
    output s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_par
  );
  modport slave (
    input  s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_par
  );
`else
  modport master (
    output s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_data, m_sof
  );
  modport slave (
    input  s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_data, m_sof
  );
`endif
endinterface

// File: rtl/lane_map_pipe.sv
// lane_map_pipe -- per-lane bit/byte mapping pipeline with 2-entry buffering.
// Build option: LANE_MAP_PARITY_EN adds bus.m_par, the even parity of each
// m_data lane, registered alongside m_data.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : s_* input stream, m_* output stream
//   mode_in, mode_load  : mode request; mode_load pulse captures mode_in as pending
//   mode_cur            : active mapping mode (0 bypass, 1 interleave,
//                         2 bit reverse, 3 lane swap)
//   beat_cnt            : accepted beats in the current frame (saturating)
module lane_map_pipe #(
  parameter int unsigned N_BYTES = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lane_map_if.slave        bus,
  input  logic [1:0]       mode_in,
  input  logic             mode_load,
  output logic [1:0]       mode_cur,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int unsigned DW = 8 * N_BYTES;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           s_ready_q;
  logic           accept, deliver, sof_acc;
  logic           ld_out_map, ld_skid, ld_out_skid;
  logic [DW-1:0]  out_data, skid_data, mapped;
  logic           out_sof, skid_sof;
  logic [1:0]     beat_mode, pend_mode;
  logic           pend_flag;

  function automatic logic [DW-1:0] map_beat(input logic [DW-1:0] d,
                                             input logic [1:0]    m);
    logic [DW-1:0] r;
    logic [7:0]    b;
    r = '0;
    for (int unsigned k = 0; k < N_BYTES; k++) begin
      b = d[8*k +: 8];
      case (m)
        2'd0:    r[8*k +: 8] = b;
        2'd1:    r[8*k +: 8] = {b[0], b[4], b[1], b[5], b[2], b[6], b[3], b[7]};
        2'd2:    r[8*k +: 8] = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
        default: r[8*k +: 8] = d[8*(N_BYTES-1-k) +: 8];
      endcase
    end
    return r;
  endfunction

  assign accept  = bus.s_valid & s_ready_q;
  assign deliver = (state != EMPTY) & bus.m_ready;
  assign sof_acc = accept & bus.s_sof;

  // A sof beat picks up a same-cycle mode_load first, else any pending mode.
  always_comb begin
    beat_mode = mode_cur;
    if (sof_acc) begin
      if (mode_load)
        beat_mode = mode_in;
      else if (pend_flag)
        beat_mode = pend_mode;
    end
  end

  assign mapped = map_beat(bus.s_data, beat_mode);

  // Buffer FSM: out register is the head; skid holds the second beat in FULL.
  always_comb begin
    state_nxt   = state;
    ld_out_map  = 1'b0;
    ld_skid     = 1'b0;
    ld_out_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt  = ONE;
          ld_out_map = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          ld_out_map = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          ld_skid   = 1'b1;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          state_nxt   = ONE;
          ld_out_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_ready_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sof   <= 1'b0;
      skid_data <= '0;
      skid_sof  <= 1'b0;
    end else begin
      if (ld_out_map) begin
        out_data <= mapped;
        out_sof  <= bus.s_sof;
      end else if (ld_out_skid) begin
        out_data <= skid_data;
        out_sof  <= skid_sof;
      end
      if (ld_skid) begin
        skid_data <= mapped;
        skid_sof  <= bus.s_sof;
      end
    end
  end

  // A mode_load that coincides with a pending value simply overwrites it and
  // stays pending; the idle-EMPTY apply then happens a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_cur  <= 2'd0;
      pend_mode <= 2'd0;
      pend_flag <= 1'b0;
    end else if (sof_acc) begin
      mode_cur  <= beat_mode;
      pend_flag <= 1'b0;
    end else if (mode_load) begin
      pend_mode <= mode_in;
      pend_flag <= 1'b1;
    end else if (pend_flag && (state == EMPTY) && !accept) begin
      mode_cur  <= pend_mode;
      pend_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (sof_acc) begin
      beat_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (accept && (beat_cnt != '1)) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = (state != EMPTY);
  assign bus.m_data  = out_data;
  assign bus.m_sof   = out_sof;

`ifdef LANE_MAP_PARITY_EN
  logic [N_BYTES-1:0] mapped_par, out_par, skid_par;

  always_comb begin
    mapped_par = '0;
    for (int unsigned k = 0; k < N_BYTES; k++)
      mapped_par[k] = ^mapped[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par  <= '0;
      skid_par <= '0;
    end else begin
      if (ld_out_map)
        out_par <= mapped_par;
      else if (ld_out_skid)
        out_par <= skid_par;
      if (ld_skid)
        skid_par <= mapped_par;
    end
  end

  assign bus.m_par = out_par;
`endif

endmodule

// File: tb/tb_lane_map_pipe.sv
// tb_lane_map_pipe -- directed self-checking bench for lane_map_pipe.
// A second instance with CNT_W=2 mirrors the main input stream to check
// beat counter saturation.
module tb_lane_map_pipe;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode_in;
  logic       mode_load;
  logic [1:0] mode_cur, mode_cur2;
  logic [15:0] beat_cnt;
  logic [1:0]  beat_cnt2;

  int tests_run    = 0;
  int tests_failed = 0;

  lane_map_if #(.N_BYTES(4)) bus  ();
  lane_map_if #(.N_BYTES(4)) bus2 ();

  lane_map_pipe #(.N_BYTES(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mode_in   (mode_in),
    .mode_load (mode_load),
    .mode_cur  (mode_cur),
    .beat_cnt  (beat_cnt)
  );

  lane_map_pipe #(.N_BYTES(4), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .mode_in   (mode_in),
    .mode_load (mode_load),
    .mode_cur  (mode_cur2),
    .beat_cnt  (beat_cnt2)
  );

  assign bus2.s_valid = bus.s_valid;
  assign bus2.s_data  = bus.s_data;
  assign bus2.s_sof   = bus.s_sof;
  assign bus2.m_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_beat(input logic [31:0] d, input logic sof);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_in   = m;
    mode_load = 1'b1;
    @(posedge clk); #1;
    mode_load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready got %b exp 0", bus.s_ready); end
    tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid); end
    tests_run++; if (bus.m_sof !== 1'b0) begin tests_failed++; $display("FAIL reset_m_sof got %b exp 0", bus.m_sof); end
    tests_run++; if (bus.m_data !== 32'h0) begin tests_failed++; $display("FAIL reset_m_data got %h exp 0", bus.m_data); end
    tests_run++; if (mode_cur !== 2'd0) begin tests_failed++; $display("FAIL reset_mode_cur got %0d exp 0", mode_cur); end
    tests_run++; if (beat_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_beat_cnt got %0d exp 0", beat_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tests_run++; if (bus.s_ready !== 1'b0) begin tests_failed++; $display("FAIL s_ready_before_edge got %b exp 0", bus.s_ready); end
    @(posedge clk); #1;
    tests_run++; if (bus.s_ready !== 1'b1) begin tests_failed++; $display("FAIL s_ready_after_edge got %b exp 1", bus.s_ready); end
    tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_m_valid got %b exp 0", bus.m_valid); end
  endtask

  task automatic test_modes();
    logic [1:0]  modes [5];
    logic [31:0] din   [5];
    logic [31:0] dexp  [5];
    modes = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    din   = '{32'h0F0F0F0F, 32'h01010101, 32'h0F01F080, 32'h11223344, 32'hDEADBEEF};
    dexp  = '{32'hAAAAAAAA, 32'h80808080, 32'hF0800F01, 32'h44332211, 32'hDEADBEEF};
    for (int i = 0; i < 5; i++) begin
      set_mode(modes[i]);
      tests_run++; if (mode_cur !== modes[i]) begin tests_failed++; $display("FAIL mode_cur[%0d] got %0d exp %0d", i, mode_cur, modes[i]); end
      send_beat(din[i], 1'b1);
      tests_run++; if (bus.m_valid !== 1'b1) begin tests_failed++; $display("FAIL map_valid[%0d] got %b exp 1", i, bus.m_valid); end
      tests_run++; if (bus.m_data !== dexp[i]) begin tests_failed++; $display("FAIL map_data[%0d] got %h exp %h", i, bus.m_data, dexp[i]); end
      tests_run++; if (bus.m_sof !== 1'b1) begin tests_failed++; $display("FAIL map_sof[%0d] got %b exp 1", i, bus.m_sof); end
    end
  endtask

`ifdef LANE_MAP_PARITY_EN
  task automatic test_parity();
    send_beat(32'h00000007, 1'b1);
    tests_run++; if (bus.m_par !== 4'b0001) begin tests_failed++; $display("FAIL parity_07 got %b exp 0001", bus.m_par); end
    send_beat(32'h01030700, 1'b1);
    tests_run++; if (bus.m_par !== 4'b1010) begin tests_failed++; $display("FAIL parity_mix got %b exp 1010", bus.m_par); end
  endtask
`endif

  task automatic test_backpressure();
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hA0A0A0A1;
    bus.s_sof   = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (bus.m_data !== 32'hA0A0A0A1) begin tests_failed++; $display("FAIL bp_e1_data got %h exp a0a0a0a1", bus.m_data); end
    tests_run++; if (bus.m_sof !== 1'b1) begin tests_failed++; $display("FAIL bp_e1_sof got %b exp 1", bus.m_sof); end
    tests_run++; if (bus.s_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_e1_ready got %b exp 1", bus.s_ready); end
    bus.s_data = 32'hB0B0B0B2;
    bus.s_sof  = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (bus.s_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_e2_ready got %b exp 0", bus.s_ready); end
    tests_run++; if (bus.m_data !== 32'hA0A0A0A1) begin tests_failed++; $display("FAIL bp_e2_data got %h exp a0a0a0a1", bus.m_data); end
    bus.s_data = 32'hC0C0C0C3;
    @(posedge clk); #1;
    tests_run++; if (bus.s_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_e3_ready got %b exp 0", bus.s_ready); end
    tests_run++; if (bus.m_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_e3_valid got %b exp 1", bus.m_valid); end
    tests_run++; if (bus.m_data !== 32'hA0A0A0A1) begin tests_failed++; $display("FAIL bp_e3_data got %h exp a0a0a0a1", bus.m_data); end
    tests_run++; if (bus.m_sof !== 1'b1) begin tests_failed++; $display("FAIL bp_e3_sof got %b exp 1", bus.m_sof); end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (bus.m_data !== 32'hB0B0B0B2) begin tests_failed++; $display("FAIL bp_e4_data got %h exp b0b0b0b2", bus.m_data); end
    tests_run++; if (bus.m_sof !== 1'b0) begin tests_failed++; $display("FAIL bp_e4_sof got %b exp 0", bus.m_sof); end
    tests_run++; if (bus.s_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_e4_ready got %b exp 1", bus.s_ready); end
    @(posedge clk); #1;
    tests_run++; if (bus.m_data !== 32'hC0C0C0C3) begin tests_failed++; $display("FAIL bp_e5_data got %h exp c0c0c0c3", bus.m_data); end
    tests_run++; if (bus.m_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_e5_valid got %b exp 1", bus.m_valid); end
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_e6_valid got %b exp 0", bus.m_valid); end
    tests_run++; if (bus.s_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_e6_ready got %b exp 1", bus.s_ready); end
  endtask

  task automatic test_mode_switch();
    logic [31:0] din  [5];
    logic        sof  [5];
    logic        ld   [5];
    logic [1:0]  min  [5];
    logic [31:0] dexp [5];
    logic [1:0]  mexp [5];
    din  = '{32'h0F01F080, 32'h12345678, 32'h0F0F0F0F, 32'h0F01F080, 32'h11223344};
    sof  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ld   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    min  = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd3};
    dexp = '{32'h0F01F080, 32'h12345678, 32'h0F0F0F0F, 32'hF0800F01, 32'h44332211};
    mexp = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3};
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = din[i];
      bus.s_sof   = sof[i];
      mode_load   = ld[i];
      mode_in     = min[i];
      @(posedge clk); #1;
      tests_run++; if (bus.m_data !== dexp[i]) begin tests_failed++; $display("FAIL sw_data[%0d] got %h exp %h", i, bus.m_data, dexp[i]); end
      tests_run++; if (mode_cur !== mexp[i]) begin tests_failed++; $display("FAIL sw_mode[%0d] got %0d exp %0d", i, mode_cur, mexp[i]); end
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    mode_load   = 1'b0;
  endtask

  task automatic test_beat_cnt();
    logic [15:0] cexp  [5];
    logic [1:0]  c2exp [5];
    cexp  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    c2exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(32'h00000055, 1'b0);
    tests_run++; if (beat_cnt !== 16'd1) begin tests_failed++; $display("FAIL cnt_pre_sof got %0d exp 1", beat_cnt); end
    tests_run++; if (beat_cnt2 !== 2'd1) begin tests_failed++; $display("FAIL cnt2_pre_sof got %0d exp 1", beat_cnt2); end
    for (int i = 0; i < 5; i++) begin
      send_beat(32'h100 + i, (i == 0));
      tests_run++; if (beat_cnt !== cexp[i]) begin tests_failed++; $display("FAIL cnt[%0d] got %0d exp %0d", i, beat_cnt, cexp[i]); end
      tests_run++; if (beat_cnt2 !== c2exp[i]) begin tests_failed++; $display("FAIL cnt2[%0d] got %0d exp %0d", i, beat_cnt2, c2exp[i]); end
    end
    send_beat(32'h00000200, 1'b1);
    tests_run++; if (beat_cnt !== 16'd1) begin tests_failed++; $display("FAIL cnt_next_sof got %0d exp 1", beat_cnt); end
    tests_run++; if (beat_cnt2 !== 2'd1) begin tests_failed++; $display("FAIL cnt2_next_sof got %0d exp 1", beat_cnt2); end
  endtask

  task automatic test_reset_full();
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    send_beat(32'hAAAA0001, 1'b1);
    send_beat(32'hAAAA0002, 1'b0);
    tests_run++; if (bus.s_ready !== 1'b0) begin tests_failed++; $display("FAIL rf_full_ready got %b exp 0", bus.s_ready); end
    tests_run++; if (bus.m_valid !== 1'b1) begin tests_failed++; $display("FAIL rf_full_valid got %b exp 1", bus.m_valid); end
    mode_in   = 2'd1;
    mode_load = 1'b1;
    @(posedge clk); #1;
    mode_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL rf_valid got %b exp 0", bus.m_valid); end
    tests_run++; if (bus.s_ready !== 1'b0) begin tests_failed++; $display("FAIL rf_ready got %b exp 0", bus.s_ready); end
    tests_run++; if (bus.m_data !== 32'h0) begin tests_failed++; $display("FAIL rf_data got %h exp 0", bus.m_data); end
    tests_run++; if (beat_cnt !== 16'd0) begin tests_failed++; $display("FAIL rf_cnt got %0d exp 0", beat_cnt); end
    @(posedge clk); #1;
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL rf_post_valid[%0d] got %b exp 0", i, bus.m_valid); end
      tests_run++; if (mode_cur !== 2'd0) begin tests_failed++; $display("FAIL rf_post_mode[%0d] got %0d exp 0", i, mode_cur); end
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_sof   = 1'b0;
    bus.m_ready = 1'b1;
    mode_in     = 2'd0;
    mode_load   = 1'b0;
    test_reset();
    test_modes();
`ifdef LANE_MAP_PARITY_EN
    test_parity();
`endif
    test_backpressure();
    test_mode_switch();
    test_beat_cnt();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lane_map_pipe.md
LANE_MAP_PIPE -- requirements
Module: lane_map_pipe

Interface
REQ-001 Parameter N_BYTES, default 4: number of 8-bit lanes per beat, legal range 1..16.
REQ-002 Parameter CNT_W, default 16: width of the per-frame beat counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 s_valid  in  1  input beat valid.
REQ-006 s_ready  out  1  block can accept a beat.
REQ-007 s_data  in  8*N_BYTES  input beat, lane k = bits [8k+7:8k].
REQ-008 s_sof  in  1  start-of-frame flag, qualified by s_valid.
REQ-009 mode_in  in  2  requested mapping mode.
REQ-010 mode_load  in  1  single-cycle pulse that captures mode_in as the pending mode.
REQ-011 m_valid  out  1  output beat valid.
REQ-012 m_ready  in  1  downstream accepts the beat.
REQ-013 m_data  out  8*N_BYTES  mapped beat.
REQ-014 m_sof  out  1  start-of-frame flag travelling with m_data.
REQ-015 mode_cur  out  2  active mapping mode.
REQ-016 beat_cnt  out  CNT_W  accepted input beats in the current frame.

Function
REQ-017 A beat is accepted when s_valid and s_ready are both 1, and is delivered when m_valid and m_ready are both 1.
REQ-018 Mode 0 is bypass: out[i] = in[i] for each lane.
REQ-019 Mode 1 is interleave, applied per lane: out[7:0] = {in0, in4, in1, in5, in2, in6, in3, in7}, listed MSB first.
REQ-020 Mode 2 is a full bit reverse per lane: out[i] = in[7-i].
REQ-021 Mode 3 is a lane swap: output lane k = input lane N_BYTES-1-k, with bits unchanged.
REQ-022 The mapping is applied at acceptance time using the mode in effect for that beat.
REQ-023 The mapped beat appears on m_data with m_valid=1 on the cycle after acceptance (latency 1), and throughput is 1 beat per cycle.
REQ-024 Buffering is a 2-entry output register plus skid register, controlled by FSM states EMPTY, ONE and FULL.
REQ-025 FSM transitions:
- EMPTY -> ONE on accept.
- ONE -> FULL on accept without deliver.
- ONE -> EMPTY on deliver without accept.
- FULL -> ONE on deliver.
- Simultaneous accept and deliver in ONE keeps the state at ONE.
REQ-026 s_ready is registered and is 0 only in FULL, so no combinational path exists from m_ready to s_ready.
REQ-027 Output order equals input order, and m_data, m_sof and m_valid are held stable while m_valid=1 and m_ready=0.
REQ-028 mode_load writes mode_in into the pending register and sets the pending flag; a later mode_load overwrites a pending value.
REQ-029 The pending mode takes effect at whichever comes first:
- the next accepted beat with s_sof=1, which is itself mapped with the new mode;
- any cycle with the FSM in EMPTY and no accept, after which mode_cur updates on the next cycle.
REQ-030 When mode_load and an accepted s_sof beat occur in the same cycle, that beat uses mode_in directly.
REQ-031 A mode change never takes effect on a non-sof beat while the FSM is in ONE or FULL.
REQ-032 beat_cnt is set to 1 on an accepted beat with s_sof=1 and incremented on every other accepted beat.
REQ-033 beat_cnt saturates at 2^CNT_W-1.
REQ-034 An accepted non-sof beat before the first sof beat increments beat_cnt normally.

Reset
REQ-035 While rst_n=0:
- FSM = EMPTY, s_ready = 0, m_valid = 0, m_sof = 0;
- m_data = 0, mode_cur = 0, pending flag cleared, beat_cnt = 0.
REQ-036 s_ready rises to 1 on the first clk edge after rst_n deasserts.
REQ-037 Reset asserted mid-transfer discards all buffered beats and any pending mode without emitting them.

Configuration
REQ-038 With LANE_MAP_PARITY_EN defined, an output m_par [N_BYTES-1:0] SHALL carry the even parity of each m_data lane, registered with m_data and reset to 0.
REQ-039 Without LANE_MAP_PARITY_EN, the m_par port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-040 Mode 1, N_BYTES=4: s_data=0x0F0F0F0F -> m_data=0xAAAAAAAA one cycle later; s_data=0x01010101 -> 0x80808080.
REQ-041 Mode 2: 0x0F01F080 -> 0xF0800F01. Mode 3: 0x11223344 -> 0x44332211. Mode 0: 0xDEADBEEF unchanged.
REQ-042 Continuous s_valid with m_ready held 0 for 3 cycles: s_ready drops after 2 accepts, no beat is lost or duplicated, and output order is preserved.
REQ-043 Mid-frame mode_load to mode 2 in mode 0: the remaining frame beats stay bypass, and the first beat of the next sof frame is bit-reversed.
REQ-044 A frame of 5 beats gives beat_cnt=5, and the next sof gives beat_cnt=1; with CNT_W=2, 5 beats gives beat_cnt=3.
REQ-045 rst_n pulsed low while in FULL gives m_valid=0 immediately, and with LANE_MAP_PARITY_EN, lane 0x07 gives m_par bit=1.
